// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader: FSM states, NOP, default halt word.
// Latency: n/a (types and constants only).
// Backpressure: n/a. Ports: none; imported by imem_loader_pipe and imem_word_asm.
package imem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_LOAD  = 2'd2,
    ST_DONE  = 2'd3
  } ld_state_e;

  // Instruction returned on stall-free error, flush and while loading.
  localparam int unsigned NOP_WORD = 0;

  // Wide enough for any sensible DATA_W; the top slices it to DATA_W.
  localparam logic [127:0] HALT_WORD_DEFAULT = '1;

endpackage

// File: rtl/imem_loader_pipe_if.sv
// Debug-unit program-load channel: load start, byte stream handshake and load status.
// Latency: n/a (wiring only); a byte moves on an edge where ld_valid && ld_ready.
// Backpressure: ld_ready low holds the byte stream. Ports: master = debug unit, slave = loader.
interface imem_loader_pipe_if #(
  parameter int DEPTH = 256
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic              ld_start;
  logic              ld_valid;
  logic [7:0]        ld_byte;
  logic              ld_ready;
  logic              ld_done;
  logic [ADDR_W:0]   ld_count;

  modport master (
    output ld_start, ld_valid, ld_byte,
    input  ld_ready, ld_done, ld_count
  );

  modport slave (
    input  ld_start, ld_valid, ld_byte,
    output ld_ready, ld_done, ld_count
  );
endinterface

// File: rtl/imem_word_asm.sv
// Packs an MSB-first byte stream into DATA_W-bit words.
// Latency: word_o/word_vld_o are combinational on the accepting cycle of the last byte.
// Backpressure: none; the caller only presents bytes it has accepted. Ports: clk, rst (async low),
//   clr_i (drop partial word), byte_vld_i/byte_i (accepted byte), word_vld_o/word_o (completed word).
module imem_word_asm #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              byte_vld_i,
  input  logic [7:0]        byte_i,
  output logic              word_vld_o,
  output logic [DATA_W-1:0] word_o
);
  localparam int NB    = DATA_W / 8;
  localparam int CNT_W = $clog2(NB + 1);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              last_byte;

  assign last_byte = (cnt_q == CNT_W'(NB - 1));
  // Older bytes fall off the top, so after NB shifts the word holds exactly the last NB bytes.
  assign word_o     = (shift_q << 8) | DATA_W'(byte_i);
  assign word_vld_o = byte_vld_i && !clr_i && last_byte;

  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    if (clr_i) begin
      cnt_d   = '0;
      shift_d = '0;
    end else if (byte_vld_i) begin
      shift_d = word_o;
      cnt_d   = last_byte ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/imem_loader_pipe.sv
// Instruction memory with a 1-cycle fetch port and a debug byte-stream program loader.
// Latency: fetch 1 cycle (registered outData); a loaded word is written on its last byte's edge.
// Backpressure: fetch_en=0 stalls/holds the fetch outputs; ld_ready low (not loading, memory full
//   or ld_start asserted) holds the byte stream.
// Ports: clk, rst (async active-low), fetch_en/flush/inAddr -> outData/out_valid/addr_err,
//   ld (imem_loader_pipe_if.slave) for the load channel.
// Build option: define IMEM_CLEAR_EN to zero the whole memory (one word per cycle) before each load.
module imem_loader_pipe
  import imem_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter int                DEPTH     = 256,
  parameter logic [DATA_W-1:0] HALT_WORD = HALT_WORD_DEFAULT[DATA_W-1:0]
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  input  logic              flush,
  input  logic [31:0]       inAddr,
  output logic [DATA_W-1:0] outData,
  output logic              out_valid,
  output logic              addr_err,
  imem_loader_pipe_if.slave ld
);
  localparam int                ADDR_W   = $clog2(DEPTH);
  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_LAST = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [DATA_W-1:0] NOP      = DATA_W'(NOP_WORD);

`ifdef IMEM_CLEAR_EN
  localparam ld_state_e START_ST = ST_CLEAR;
`else
  localparam ld_state_e START_ST = ST_LOAD;
`endif

  ld_state_e         state_q, state_d;
  logic [ADDR_W:0]   ld_count_q, ld_count_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              addr_err_q, addr_err_d;
`ifdef IMEM_CLEAR_EN
  logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
`endif

  logic [DATA_W-1:0] mem [DEPTH];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  logic              ld_ready_w;
  logic              byte_acc;
  logic              word_vld;
  logic [DATA_W-1:0] word;
  logic [ADDR_W-1:0] fetch_idx;
  logic              addr_bad;
  logic              loading;

  // ld_start wins over a simultaneous byte, so refuse the byte rather than silently drop it.
  assign ld_ready_w = (state_q == ST_LOAD) && (ld_count_q < CNT_FULL) && !ld.ld_start;
  assign byte_acc   = ld.ld_valid && ld_ready_w;

  assign fetch_idx = inAddr[ADDR_W+1:2];
  assign addr_bad  = (|inAddr[1:0]) || (|inAddr[31:ADDR_W+2]);

  imem_word_asm #(.DATA_W(DATA_W)) u_word_asm (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (ld.ld_start),
    .byte_vld_i (byte_acc),
    .byte_i     (ld.ld_byte),
    .word_vld_o (word_vld),
    .word_o     (word)
  );

  always_comb begin
    state_d    = state_q;
    ld_count_d = ld_count_q;
    mem_we     = 1'b0;
    mem_waddr  = ld_count_q[ADDR_W-1:0];
    mem_wdata  = word;
`ifdef IMEM_CLEAR_EN
    clr_idx_d  = clr_idx_q;
`endif

    if (ld.ld_start) begin
      state_d    = START_ST;
      ld_count_d = '0;
`ifdef IMEM_CLEAR_EN
      clr_idx_d  = '0;
`endif
    end else begin
      case (state_q)
`ifdef IMEM_CLEAR_EN
        ST_CLEAR: begin
          mem_we    = 1'b1;
          mem_waddr = clr_idx_q;
          mem_wdata = NOP;
          clr_idx_d = clr_idx_q + 1'b1;
          if (clr_idx_q == ADDR_W'(DEPTH - 1)) state_d = ST_LOAD;
        end
`endif
        ST_LOAD: begin
          if (word_vld) begin
            mem_we     = 1'b1;
            ld_count_d = ld_count_q + 1'b1;
            // The halt word is stored too; a full memory ends the load without wrapping.
            if (word == HALT_WORD || ld_count_q == CNT_LAST) state_d = ST_DONE;
          end
        end
        default: state_d = state_q;
      endcase
    end

    // Fetch path. Loading is checked on both sides of the edge so the port never shows a word
    // that is being rewritten, including the edge that writes the final word.
    loading     = (state_q inside {ST_CLEAR, ST_LOAD}) || (state_d inside {ST_CLEAR, ST_LOAD});
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    addr_err_d  = 1'b0;
    if (loading || flush) begin
      out_data_d  = NOP;
      out_valid_d = 1'b0;
    end else if (fetch_en) begin
      if (addr_bad) begin
        out_data_d  = NOP;
        out_valid_d = 1'b0;
        addr_err_d  = 1'b1;
      end else begin
        out_data_d  = mem[fetch_idx];
        out_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      ld_count_q  <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      addr_err_q  <= 1'b0;
`ifdef IMEM_CLEAR_EN
      clr_idx_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ld_count_q  <= ld_count_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      addr_err_q  <= addr_err_d;
`ifdef IMEM_CLEAR_EN
      clr_idx_q   <= clr_idx_d;
`endif
    end
  end

  // Contents survive reset on purpose: a reset mid-load leaves already-written words in place.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign outData     = out_data_q;
  assign out_valid   = out_valid_q;
  assign addr_err    = addr_err_q;
  assign ld.ld_ready = ld_ready_w;
  assign ld.ld_done  = (state_q == ST_DONE);
  assign ld.ld_count = ld_count_q;

endmodule

// File: tb/tb_imem_loader_pipe.sv
module tb_imem_loader_pipe;
  localparam int DW = 32;
  localparam int D  = 16;
  localparam int AW = 4;
  localparam int D4 = 4;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;
`ifdef IMEM_CLEAR_EN
  localparam int CLR_CYCLES = D;
`else
  localparam int CLR_CYCLES = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          fetch_en = 1'b0;
  logic          flush    = 1'b0;
  logic [31:0]   inAddr   = '0;
  logic [DW-1:0] outData, outData4;
  logic          out_valid, addr_err, out_valid4, addr_err4;

  imem_loader_pipe_if #(.DEPTH(D))  ldif  ();
  imem_loader_pipe_if #(.DEPTH(D4)) ldif4 ();

  imem_loader_pipe #(.DATA_W(DW), .DEPTH(D)) u_dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .flush(flush), .inAddr(inAddr),
    .outData(outData), .out_valid(out_valid), .addr_err(addr_err), .ld(ldif.slave)
  );

  imem_loader_pipe #(.DATA_W(DW), .DEPTH(D4)) u_dut4 (
    .clk(clk), .rst(rst), .fetch_en(1'b0), .flush(1'b0), .inAddr(32'h0),
    .outData(outData4), .out_valid(out_valid4), .addr_err(addr_err4), .ld(ldif4.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: memory image, written flags, pending bytes of the current word.
  logic [31:0] ref_mem [D];
  bit          ref_wr  [D];
  logic [7:0]  acc_q [$];
  int          mcount;
  bit          mdone;
  logic [31:0] e_dat;
  logic        e_vld;
  logic [7:0]  prog [12];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_start();
    acc_q.delete();
    mcount = 0;
    mdone  = 1'b0;
    e_dat  = '0;
    e_vld  = 1'b0;
`ifdef IMEM_CLEAR_EN
    for (int i = 0; i < D; i++) begin
      ref_mem[i] = '0;
      ref_wr[i]  = 1'b1;
    end
`endif
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic [31:0] w;
    acc_q.push_back(b);
    if (acc_q.size() == 4) begin
      w = {acc_q[0], acc_q[1], acc_q[2], acc_q[3]};
      acc_q.delete();
      ref_mem[mcount[AW-1:0]] = w;
      ref_wr[mcount[AW-1:0]]  = 1'b1;
      mcount++;
      if (w == HALT || mcount == D) mdone = 1'b1;
    end
  endtask

  // All drive tasks are entered at (or just after) a falling edge.
  task automatic start_load(input bit sel);
    int n;
    if (sel) ldif4.ld_start = 1'b1; else ldif.ld_start = 1'b1;
    @(negedge clk);
    ldif.ld_start  = 1'b0;
    ldif4.ld_start = 1'b0;
    #1;
    if (!sel) begin
      model_start();
      n = 0;
      while (!ldif.ld_ready && n < 200) begin
        @(negedge clk);
        n++;
      end
      chk("ld_ready_low_cycles", 64'(n), 64'(CLR_CYCLES));
      chk("ld_done_after_start", 64'(ldif.ld_done), 64'd0);
    end
  endtask

  task automatic send_byte(input bit sel, input logic [7:0] b);
    int n;
    bit rdy;
    n = 0;
    if (sel) begin ldif4.ld_valid = 1'b1; ldif4.ld_byte = b; end
    else     begin ldif.ld_valid  = 1'b1; ldif.ld_byte  = b; end
    #1;
    rdy = sel ? ldif4.ld_ready : ldif.ld_ready;
    while (!rdy && n < 40) begin
      @(negedge clk);
      n++;
      rdy = sel ? ldif4.ld_ready : ldif.ld_ready;
    end
    chk("byte_accept_timeout", 64'(rdy), 64'd1);
    @(negedge clk);
    ldif.ld_valid  = 1'b0;
    ldif4.ld_valid = 1'b0;
    if (rdy && !sel) model_byte(b);
  endtask

  task automatic send_word(input bit sel, input logic [31:0] w);
    logic [31:0] t;
    t = w;
    for (int i = 0; i < 4; i++) begin
      send_byte(sel, t[31:24]);
      t = t << 8;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic fetch_step(input logic fe, input logic fl, input logic [31:0] a, input string tag);
    logic e_err;
    fetch_en = fe;
    flush    = fl;
    inAddr   = a;
    e_err    = 1'b0;
    if (fl) begin
      e_dat = '0;
      e_vld = 1'b0;
    end else if (fe) begin
      if (a[1:0] != 2'b00 || a >= 32'(4 * D)) begin
        e_dat = '0;
        e_vld = 1'b0;
        e_err = 1'b1;
      end else begin
        e_dat = ref_mem[a[AW+1:2]];
        e_vld = 1'b1;
      end
    end
    @(negedge clk);
    chk({tag, "_data"},  64'(outData),   64'(e_dat));
    chk({tag, "_valid"}, 64'(out_valid), 64'(e_vld));
    chk({tag, "_err"},   64'(addr_err),  64'(e_err));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w, a;
    int k, idx, guard;

    ldif.ld_start  = 1'b0; ldif.ld_valid  = 1'b0; ldif.ld_byte  = '0;
    ldif4.ld_start = 1'b0; ldif4.ld_valid = 1'b0; ldif4.ld_byte = '0;
    for (int i = 0; i < D; i++) begin
      ref_mem[i] = '0;
      ref_wr[i]  = 1'b0;
    end
    mcount = 0; mdone = 1'b0; e_dat = '0; e_vld = 1'b0;
    prog = '{8'h20, 8'h01, 8'h00, 8'h08, 8'h20, 8'h02, 8'h00, 8'h03,
             8'hFF, 8'hFF, 8'hFF, 8'hFF};

    // Reset values, observed while reset is held.
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_outData",   64'(outData),       64'd0);
    chk("rst_out_valid", 64'(out_valid),     64'd0);
    chk("rst_addr_err",  64'(addr_err),      64'd0);
    chk("rst_ld_ready",  64'(ldif.ld_ready), 64'd0);
    chk("rst_ld_done",   64'(ldif.ld_done),  64'd0);
    chk("rst_ld_count",  64'(ldif.ld_count), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_ld_ready", 64'(ldif.ld_ready), 64'd0);

    // Directed program load terminated by the halt word.
    start_load(0);
    for (int i = 0; i < 12; i++) send_byte(0, prog[i]);
    chk("prog_ld_count", 64'(ldif.ld_count), 64'd3);
    chk("prog_ld_done",  64'(ldif.ld_done),  64'd1);
    chk("prog_ld_ready", 64'(ldif.ld_ready), 64'd0);

    // Fetch, misaligned, pulse drop, out of range.
    fetch_step(1, 0, 32'h4, "f4");
    chk("f4_const", 64'(outData), 64'h2002_0003);
    fetch_step(1, 0, 32'h6, "mis6");
    fetch_step(1, 0, 32'h0, "f0");
    chk("f0_const", 64'(outData), 64'h2001_0008);
    fetch_step(1, 0, 32'h40, "oor");
    fetch_step(1, 0, 32'h8, "f8");

    // Stall holds output with changing address; flush beats stall.
    fetch_step(1, 0, 32'h4, "pre_stall");
    for (int i = 0; i < 3; i++) fetch_step(0, 0, $urandom(), "stall");
    chk("stall_const", 64'(outData), 64'h2002_0003);
    fetch_step(0, 1, 32'h4, "flush_stall");
    fetch_step(1, 0, 32'h0, "post_flush");

    // Restart mid-word, with ld_start and ld_valid raised together.
    fetch_en = 1'b1; flush = 1'b0; inAddr = 32'h0;
    start_load(0);
    chk("load_out_valid", 64'(out_valid), 64'd0);
    chk("load_outData",   64'(outData),   64'd0);
    send_byte(0, 8'hAA);
    send_byte(0, 8'hBB);
    ldif.ld_start = 1'b1; ldif.ld_valid = 1'b1; ldif.ld_byte = 8'hCC;
    @(negedge clk);
    ldif.ld_start = 1'b0; ldif.ld_valid = 1'b0;
    model_start();
    chk("restart_count0", 64'(ldif.ld_count), 64'd0);
    send_word(0, 32'h1122_3344);
    chk("restart_count1", 64'(ldif.ld_count), 64'd1);
    chk("restart_done0",  64'(ldif.ld_done),  64'd0);
    send_word(0, HALT);
    chk("restart_done1",  64'(ldif.ld_done),  64'd1);
    fetch_step(1, 0, 32'h0, "restart_m0");
    chk("restart_m0_const", 64'(outData), 64'h1122_3344);

    // Randomised loads followed by randomised fetch/stall/flush traffic.
    for (int r = 0; r < 8; r++) begin
      k = $urandom_range(1, D);
      start_load(0);
      for (int j = 0; j < k; j++) begin
        w = $urandom();
        if (w == HALT) w = 32'h0;
        send_word(0, w);
      end
      if (k < D) send_word(0, HALT);
      chk("rnd_count_model", 64'(ldif.ld_count), 64'(mcount));
      chk("rnd_count_rule",  64'(ldif.ld_count), 64'((k < D) ? k + 1 : D));
      chk("rnd_done",        64'(ldif.ld_done),  64'(mdone));
      chk("rnd_ready",       64'(ldif.ld_ready), 64'd0);
      for (int s = 0; s < 24; s++) begin
        idx = $urandom_range(0, D - 1);
        guard = 0;
        while (!ref_wr[idx] && guard < D) begin
          idx = (idx + 1) % D;
          guard++;
        end
        a = 32'(idx * 4);
        case ($urandom_range(0, 9))
          0: a = a + 32'($urandom_range(1, 3));
          1: a = $urandom() | 32'h40;
          default: ;
        endcase
        fetch_step((s == 0) || ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0), a, "rnd");
      end
    end

    // Reload a single word over a fuller image: word 3 is zeroed by the clear, otherwise stale.
    start_load(0);
    for (int j = 0; j < 4; j++) send_word(0, 32'hA000_0000 + 32'(j));
    send_word(0, HALT);
    start_load(0);
    send_word(0, 32'h1234_5678);
    send_word(0, HALT);
    chk("reload_count", 64'(ldif.ld_count), 64'd2);
    fetch_step(1, 0, 32'hC, "reload_m3");
`ifdef IMEM_CLEAR_EN
    chk("reload_m3_const", 64'(outData), 64'd0);
`else
    chk("reload_m3_const", 64'(outData), 64'hA000_0003);
`endif
    fetch_step(1, 0, 32'h0, "reload_m0");

    // Small memory fills up with no halt word and then refuses further bytes.
    start_load(1);
    for (int i = 0; i < 4 * D4; i++) send_byte(1, 8'($urandom_range(0, 254)));
    chk("full_count", 64'(ldif4.ld_count), 64'(D4));
    chk("full_done",  64'(ldif4.ld_done),  64'd1);
    chk("full_ready", 64'(ldif4.ld_ready), 64'd0);
    ldif4.ld_valid = 1'b1; ldif4.ld_byte = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("byte17_ready", 64'(ldif4.ld_ready), 64'd0);
      chk("byte17_count", 64'(ldif4.ld_count), 64'(D4));
    end
    ldif4.ld_valid = 1'b0;
    chk("dut4_out_valid", 64'(out_valid4), 64'd0);
    chk("dut4_outData",   64'(outData4),   64'd0);
    chk("dut4_addr_err",  64'(addr_err4),  64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imem_loader_pipe.md
IMEM_LOADER_PIPE -- requirements
Module: imem_loader_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 32, instruction width in bits (multiple of 8).
REQ-002 SHALL have parameter DEPTH, default 256, number of instruction words (power of two, >= 4).
REQ-003 SHALL have parameter HALT_WORD, default all-ones, instruction value that terminates a load.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port fetch_en  in  1  pipeline enable; 0 = stall, hold outputs.
REQ-007 SHALL have port flush  in  1  replace the next fetched word with NOP.
REQ-008 SHALL have port inAddr  in  32  byte address from PC; word index = inAddr[ADDR_W+1:2], ADDR_W = clog2(DEPTH).
REQ-009 SHALL have port outData  out  DATA_W  registered fetched instruction.
REQ-010 SHALL have port out_valid  out  1  outData holds a real fetched word.
REQ-011 SHALL have port addr_err  out  1  one-cycle pulse: fetch beyond DEPTH or inAddr[1:0] != 0.
REQ-012 SHALL have port ld_start  in  1  debug unit begins a new program load.
REQ-013 SHALL have ports ld_valid in 1, ld_byte in 8, ld_ready out 1: byte-stream handshake, transfer when ld_valid && ld_ready.
REQ-014 SHALL have port ld_done  out  1  level, high after load completes until next ld_start.
REQ-015 SHALL have port ld_count  out  ADDR_W+1  words written in current/last load.

Function
REQ-016 SHALL implement FSM IDLE, CLEAR (macro-dependent), LOAD, DONE; IDLE -ld_start-> CLEAR or LOAD; LOAD -halt/full-> DONE; DONE -ld_start-> CLEAR or LOAD.
REQ-017 SHALL fetch with 1-cycle latency in IDLE/DONE: with fetch_en=1, outData = mem[index of inAddr sampled previous edge], out_valid=1.
REQ-018 SHALL hold outData, out_valid unchanged when fetch_en=0; flush has priority over stall, forcing outData=0 (NOP), out_valid=0.
REQ-019 SHALL on out-of-range or misaligned fetch return outData=0, out_valid=0, pulse addr_err for one cycle.
REQ-020 SHALL in CLEAR/LOAD force outData=0, out_valid=0, ignore fetch_en.
REQ-021 SHALL assemble bytes MSB-first: first accepted byte -> bits [DATA_W-1:DATA_W-8]; word written at ld_count on the edge accepting its last byte, then ld_count+1.
REQ-022 SHALL assert ld_ready only in LOAD with ld_count < DEPTH.
REQ-023 SHALL on a written word equal to HALT_WORD store it, increment ld_count, enter DONE, assert ld_done next cycle.
REQ-024 SHALL on ld_count reaching DEPTH enter DONE (no wrap); further bytes are not accepted.
REQ-025 SHALL on ld_start in any state (including mid-word in LOAD) discard partial byte accumulator, reset ld_count to 0, deassert ld_done; ld_start beats simultaneous ld_valid.

Reset
REQ-026 SHALL on rst low asynchronously set state IDLE, outData=0, out_valid=0, addr_err=0, ld_ready=0, ld_done=0, ld_count=0, byte accumulator empty.
REQ-027 SHALL NOT reset memory array contents; reset mid-load leaves partially written words in place.

Configuration
REQ-028 SHALL honour macro IMEM_CLEAR_EN: defined -> ld_start enters CLEAR, writes 0 to one word per cycle for DEPTH cycles (ld_ready=0), then LOAD.
REQ-029 SHALL with IMEM_CLEAR_EN undefined omit CLEAR; ld_start enters LOAD next cycle, words beyond ld_count keep stale contents.

Structure
REQ-030 SHALL place FSM state enum, NOP constant (0) and default HALT_WORD in shared package imem_pkg.
REQ-031 SHALL implement byte-to-word packing in sub-module imem_word_asm (byte count, shift register, word_valid pulse).

Verification
REQ-032 SHALL test load 8 bytes 20,01,00,08,20,02,00,03 then FF,FF,FF,FF -> mem[0]=0x20010008, mem[1]=0x20020003, ld_count=3, ld_done=1.
REQ-033 SHALL test fetch inAddr=0x4 fetch_en=1 -> next cycle outData=0x20020003, out_valid=1; inAddr=0x6 -> addr_err pulse, outData=0.
REQ-034 SHALL test stall fetch_en=0 for 3 cycles with changing inAddr -> outData constant; flush=1 while stalled -> outData=0 next cycle.
REQ-035 SHALL test ld_start after 2 bytes of a word -> accumulator discarded, next 4 bytes land in mem[0], ld_count=1.
REQ-036 SHALL test DEPTH=4, 16 non-halt bytes -> ld_count=4, ld_done=1, ld_ready=0, 17th byte not accepted.
REQ-037 SHALL test with IMEM_CLEAR_EN: ld_start -> ld_ready low exactly DEPTH cycles, prior mem[3] reads 0 after reload of 1 word.
